// File: rtl/bus_split_pkg.sv
// bus_split_pkg: shared state encoding and parameter defaults for the bus split stage
package bus_split_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  localparam int WIDTH_DEF = 2;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/bus_split_skid.sv
// bus_split_skid: 2-entry skid buffer (head/tail) with registered src_ready
module bus_split_skid
  import bus_split_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] src_bus,
  input  logic             flush,
  output logic             sink_valid,
  input  logic             sink_ready,
  output logic [WIDTH-1:0] head
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic ready_q, ready_d;
  logic src_fire, sink_fire;
  assign src_fire  = src_valid & ready_q;
  assign sink_fire = sink_valid & sink_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= ready_d;
    end
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) state_d = EMPTY;
    else
      case (state_q)
        EMPTY: if (src_fire) begin
          state_d = ONE;
          head_d  = src_bus;
        end
        ONE: begin
          state_d = src_fire == sink_fire ? ONE : (src_fire ? FULL : EMPTY);
          head_d  = src_fire && sink_fire ? src_bus : head_q;
          tail_d  = src_fire && !sink_fire ? src_bus : tail_q;
        end
        FULL: if (sink_fire) begin
          state_d = ONE;
          head_d  = tail_q;
        end
        default: state_d = EMPTY;
      endcase
    ready_d = state_d != FULL;
  end
  always_comb begin
    sink_valid = state_q != EMPTY;
    src_ready  = ready_q;
    head       = head_q;
  end
  a_no_fire_full: assert property (@(posedge clk) disable iff (!rst_n) !(state_q == FULL && src_fire));
endmodule

// File: rtl/bus_split_stage.sv
// bus_split_stage: skid-buffered word split into a lane-cleared bus and a scalar, with transfer count
module bus_split_stage
  import bus_split_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int SCALAR_IDX = 0,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] src_bus,
  input  logic             flush,
  output logic             sink_valid,
  input  logic             sink_ready,
  output logic [WIDTH-1:0] sink_bus,
  output logic             scalar_sink,
  output logic [CNT_W-1:0] xfer_count
);
  localparam logic [WIDTH-1:0] LANE = WIDTH'(1) << SCALAR_IDX;
  logic [WIDTH-1:0] head;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bus_split_skid #(.WIDTH(WIDTH)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_bus    (src_bus),
    .flush      (flush),
    .sink_valid (sink_valid),
    .sink_ready (sink_ready),
    .head       (head)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(sink_valid & sink_ready);
    sink_bus    = sink_valid ? head & ~LANE : '0;
    scalar_sink = sink_valid & head[SCALAR_IDX];
    xfer_count  = cnt_q;
  end
  a_idx_range: assert property (@(posedge clk) SCALAR_IDX < WIDTH);
endmodule

// File: tb/tb_bus_split_stage.sv
// tb_bus_split_stage: table vectors, directed corner cases and random traffic against a queue model
module tb_bus_split_stage;
  logic clk = 1'b0, rst_n = 1'b0, src_valid = 1'b0, flush = 1'b0, sink_ready = 1'b0;
  logic [1:0] src_bus = 2'b00;
  logic a_src_ready, a_sink_valid, a_scalar, b_src_ready, b_sink_valid, b_scalar;
  logic [1:0] a_sink_bus, b_sink_bus, b_cnt;
  logic [7:0] a_cnt;
  int n_chk = 0, n_fail = 0;
  logic [1:0] q[$];
  int m_cnt = 0;
  logic m_rdy = 1'b0;

  bus_split_stage #(.WIDTH(2), .SCALAR_IDX(0), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(a_src_ready), .src_bus(src_bus),
    .flush(flush), .sink_valid(a_sink_valid), .sink_ready(sink_ready), .sink_bus(a_sink_bus),
    .scalar_sink(a_scalar), .xfer_count(a_cnt));
  bus_split_stage #(.WIDTH(2), .SCALAR_IDX(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(b_src_ready), .src_bus(src_bus),
    .flush(flush), .sink_valid(b_sink_valid), .sink_ready(sink_ready), .sink_bus(b_sink_bus),
    .scalar_sink(b_scalar), .xfer_count(b_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [1:0] h;
    h = q.size() != 0 ? q[0] : 2'b00;
    chk("a_src_ready", 32'(a_src_ready), 32'(m_rdy));
    chk("a_sink_valid", 32'(a_sink_valid), 32'(q.size() != 0));
    chk("a_sink_bus", 32'(a_sink_bus), 32'(h & 2'b10));
    chk("a_scalar", 32'(a_scalar), 32'(h[0]));
    chk("a_cnt", 32'(a_cnt), 32'(m_cnt % 256));
    chk("b_src_ready", 32'(b_src_ready), 32'(m_rdy));
    chk("b_sink_valid", 32'(b_sink_valid), 32'(q.size() != 0));
    chk("b_sink_bus", 32'(b_sink_bus), 32'(h & 2'b01));
    chk("b_scalar", 32'(b_scalar), 32'(h[1]));
    chk("b_cnt", 32'(b_cnt), 32'(m_cnt % 4));
  endtask

  task automatic step();
    bit sf, af;
    @(posedge clk);
    sf = q.size() != 0 && sink_ready;
    af = src_valid && m_rdy;
    if (flush) q.delete();
    else begin
      if (sf) void'(q.pop_front());
      if (af) q.push_back(src_bus);
    end
    if (sf) m_cnt++;
    m_rdy = q.size() < 2;
    #1;
    check_model();
  endtask

  task automatic do_reset();
    src_valid = 1'b0; flush = 1'b0; sink_ready = 1'b0;
    rst_n = 1'b0;
    q.delete(); m_cnt = 0; m_rdy = 1'b0;
    #1;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    logic sv; logic [1:0] bus; logic sr; logic fl;
    logic ev; logic [1:0] eb; logic es; logic er; logic [7:0] ec;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'd0};
    tbl[1] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 8'd0};
    tbl[2] = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 8'd0};
    tbl[3] = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 8'd1};
    tbl[4] = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 8'd2};
    tbl[5] = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 8'd3};
    #2;
    chk("rst_src_ready", 32'(a_src_ready), 32'd0);
    chk("rst_sink_valid", 32'(a_sink_valid), 32'd0);
    chk("rst_sink_bus", 32'(a_sink_bus), 32'd0);
    chk("rst_scalar", 32'(a_scalar), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    do_reset();
    chk("rel_src_ready", 32'(a_src_ready), 32'd1);
    chk("rel_sink_valid", 32'(a_sink_valid), 32'd0);
    // single word
    src_valid = 1'b1; src_bus = 2'b11; sink_ready = 1'b1;
    step();
    chk("single_valid", 32'(a_sink_valid), 32'd1);
    chk("single_bus", 32'(a_sink_bus), 32'd2);
    chk("single_scalar", 32'(a_scalar), 32'd1);
    chk("single_b_bus", 32'(b_sink_bus), 32'd1);
    src_valid = 1'b0;
    step();
    chk("single_cnt", 32'(a_cnt), 32'd1);
    chk("single_empty", 32'(a_sink_valid), 32'd0);
    // backpressure table
    do_reset();
    foreach (tbl[i]) begin
      src_valid = tbl[i].sv; src_bus = tbl[i].bus; sink_ready = tbl[i].sr; flush = tbl[i].fl;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(a_sink_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_bus", i), 32'(a_sink_bus), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d_scalar", i), 32'(a_scalar), 32'(tbl[i].es));
      chk($sformatf("tbl%0d_ready", i), 32'(a_src_ready), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_cnt", i), 32'(a_cnt), 32'(tbl[i].ec));
    end
    // streaming
    do_reset();
    sink_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_valid = 1'b1; src_bus = 2'(i);
      step();
      chk("stream_bus", 32'(a_sink_bus), 32'(i & 2));
      chk("stream_scalar", 32'(a_scalar), 32'(i & 1));
      chk("stream_ready", 32'(a_src_ready), 32'd1);
    end
    src_valid = 1'b0;
    step();
    chk("stream_cnt", 32'(a_cnt), 32'd4);
    chk("stream_b_cnt", 32'(b_cnt), 32'd0);
    // flush collision
    do_reset();
    src_valid = 1'b1; src_bus = 2'b01;
    step();
    src_bus = 2'b10; flush = 1'b1;
    step();
    flush = 1'b0; src_valid = 1'b0;
    chk("flush_valid", 32'(a_sink_valid), 32'd0);
    chk("flush_ready", 32'(a_src_ready), 32'd1);
    chk("flush_cnt", 32'(a_cnt), 32'd0);
    step();
    chk("flush_stays_empty", 32'(a_sink_valid), 32'd0);
    // wrap then async reset mid-stream
    do_reset();
    sink_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      src_valid = 1'b1; src_bus = 2'(i + 1);
      step();
    end
    src_valid = 1'b0;
    step();
    chk("wrap_b_cnt", 32'(b_cnt), 32'd1);
    chk("wrap_a_cnt", 32'(a_cnt), 32'd5);
    src_valid = 1'b1; src_bus = 2'b11; sink_ready = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ready", 32'(a_src_ready), 32'd0);
    chk("async_valid", 32'(a_sink_valid), 32'd0);
    chk("async_bus", 32'(a_sink_bus), 32'd0);
    chk("async_scalar", 32'(a_scalar), 32'd0);
    chk("async_cnt", 32'(a_cnt), 32'd0);
    chk("async_b_cnt", 32'(b_cnt), 32'd0);
    do_reset();
    // random traffic; src_bus only changes when no offer is pending
    for (int i = 0; i < 500; i++) begin
      if (!(src_valid && !m_rdy)) begin
        src_valid = 1'($urandom_range(0, 3) != 0);
        src_bus = 2'($urandom);
      end
      sink_ready = 1'($urandom_range(0, 2) != 0);
      flush = 1'($urandom_range(0, 29) == 0);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
